// File: rtl/dff_pipe_elastic_pkg.sv
// Shared constants and helpers for the elastic register pipe and its sibling
// datapath registers.
package dff_pipe_elastic_pkg;

    // Reset value used by datapath registers unless a block overrides it.
    localparam logic [63:0] DP_RST_VAL = 64'h0;

    // Ceiling log2. A result of 0 is promoted to 1 so that a counter derived
    // from it is never zero bits wide.
    function automatic int unsigned pipe_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dff_pipe_elastic_pipe_stage.sv
// One elastic pipe stage: a data register plus its valid bit.
// Data is written only when a valid word is loaded, so idle stages do not
// toggle. Flush clears the valid bit but leaves the data in place.
module dff_pipe_elastic_pipe_stage #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             c,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] q
);

    logic             r_v;
    logic [WIDTH-1:0] r_data;

    // Valid and data state; rst beats flush, and flush beats load.
    always_ff @(posedge c) begin
        if (rst) begin
            r_v    <= 1'b0;
            r_data <= RST_VAL;
        end else if (flush) begin
            r_v    <= 1'b0;
        end else if (load) begin
            r_v <= v_in;
            if (v_in) begin
                r_data <= d_in;
            end
        end
    end

    assign v = r_v;
    assign q = r_data;

endmodule

// File: rtl/dff_pipe_elastic.sv
// Elastic chain of DEPTH registers with a ready/valid handshake at both ends.
// Back-pressure travels combinationally down the ready chain. A stage loads
// whenever it is empty or the stage after it is loading, so any bubbles
// collapse as the words advance.
module dff_pipe_elastic
    import dff_pipe_elastic_pkg::*;
#(
    parameter int unsigned      WIDTH   = 16,
    parameter int unsigned      DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DP_RST_VAL),
    parameter int unsigned      CNT_W   = pipe_clog2(DEPTH + 1)
) (
    input  logic             c,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH:0]                w_rdy;
    logic [DEPTH-1:0]              w_v;
    logic [DEPTH-1:0]              w_v_in;
    logic [DEPTH-1:0][WIDTH-1:0]   w_data;
    logic [DEPTH-1:0][WIDTH-1:0]   w_d_in;
    logic                          w_in_xfer;
    logic                          w_out_xfer;
    logic [CNT_W-1:0]              r_count;

    // The last stage is ready whenever downstream is ready.
    assign w_rdy[DEPTH] = out_ready;

    assign in_ready   = w_rdy[0] & ~flush & ~rst;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_v_in[i] = w_in_xfer;
            assign w_d_in[i] = d;
        end else begin : g_body
            assign w_v_in[i] = w_v[i-1];
            assign w_d_in[i] = w_data[i-1];
        end

        assign w_rdy[i] = ~w_v[i] | w_rdy[i+1];

        dff_pipe_elastic_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .c     (c),
            .rst   (rst),
            .flush (flush),
            .load  (w_rdy[i]),
            .v_in  (w_v_in[i]),
            .d_in  (w_d_in[i]),
            .v     (w_v[i]),
            .q     (w_data[i])
        );
    end

    // Occupancy: +1 on input-only, -1 on output-only, cleared by rst or flush.
    always_ff @(posedge c) begin
        if (rst || flush) begin
            r_count <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_out_xfer && !w_in_xfer) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign out_valid = w_v[DEPTH-1];
    assign q         = w_data[DEPTH-1];
    assign count     = r_count;

endmodule

// File: tb/tb_dff_pipe_elastic.sv
// Directed bench for dff_pipe_elastic at WIDTH=16 and DEPTH=3.
module tb_dff_pipe_elastic;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = 2;

    logic             c = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 c = ~c;

    dff_pipe_elastic #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (16'h0000),
        .CNT_W   (CNT_W)
    ) u_dut (
        .c         (c),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .count     (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge c);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] data, input logic ordy);
        in_valid  = v;
        d         = data;
        out_ready = ordy;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b1, 16'hAAAA, 1'b1);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_q", {16'd0, q}, 32'h0000);
        check_eq("rst_count", {30'd0, count}, 32'd0);
        check_eq("rst_in_ready2", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b1);

        // Streaming 1..5 with downstream always ready.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 16'(i), 1'b1);
            check_eq("stream_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check_eq("stream_count", {30'd0, count}, (i < 3) ? i : 3);
            check_eq("stream_out_valid", {31'd0, out_valid}, (i >= 3) ? 1 : 0);
            if (i >= 3) check_eq("stream_q", {16'd0, q}, i - 2);
        end
        drive(1'b0, 16'h0000, 1'b1);
        for (int j = 0; j < 3; j++) begin
            tick();
            check_eq("drain_count", {30'd0, count}, 2 - j);
            check_eq("drain_out_valid", {31'd0, out_valid}, (j < 2) ? 1 : 0);
            if (j < 2) check_eq("drain_q", {16'd0, q}, 4 + j);
        end

        // Back-pressure fill, then release one word.
        drive(1'b1, 16'hABCD, 1'b0); tick();
        drive(1'b1, 16'hFFFF, 1'b0); tick();
        drive(1'b1, 16'h1234, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b0);
        check_eq("bp_count", {30'd0, count}, 32'd3);
        check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("bp_q", {16'd0, q}, 32'hABCD);
        drive(1'b0, 16'h0000, 1'b1); tick();
        drive(1'b0, 16'h0000, 1'b0);
        check_eq("bp_release_q", {16'd0, q}, 32'hFFFF);
        check_eq("bp_release_count", {30'd0, count}, 32'd2);
        drive(1'b0, 16'h0000, 1'b1); tick();
        check_eq("bp_drain_q", {16'd0, q}, 32'h1234);
        tick();
        check_eq("bp_empty_count", {30'd0, count}, 32'd0);
        check_eq("bp_empty_valid", {31'd0, out_valid}, 32'd0);

        // Bubbles collapse under back-pressure.
        drive(1'b1, 16'h0A0A, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b0); tick(); tick();
        drive(1'b1, 16'h0B0B, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b0); tick();
        check_eq("bub_count", {30'd0, count}, 32'd2);
        check_eq("bub_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("bub_q", {16'd0, q}, 32'h0A0A);
        check_eq("bub_out_valid", {31'd0, out_valid}, 32'd1);

        // Fill to full; a stalled full pipe ignores d.
        drive(1'b1, 16'hC0C0, 1'b0); tick();
        drive(1'b1, 16'h1111, 1'b0);
        check_eq("full_count", {30'd0, count}, 32'd3);
        check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_eq("full_hold_count", {30'd0, count}, 32'd3);
        check_eq("full_hold_q", {16'd0, q}, 32'h0A0A);

        // Simultaneous accept and drain while full.
        drive(1'b1, 16'h0000, 1'b1);
        check_eq("sim_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_eq("sim_count", {30'd0, count}, 32'd3);
        check_eq("sim_q", {16'd0, q}, 32'h0B0B);
        drive(1'b0, 16'h0000, 1'b1); tick();
        check_eq("sim_q2", {16'd0, q}, 32'hC0C0);
        check_eq("sim_count2", {30'd0, count}, 32'd2);
        tick();
        check_eq("sim_q3", {16'd0, q}, 32'h0000);
        check_eq("sim_valid3", {31'd0, out_valid}, 32'd1);
        tick();
        check_eq("sim_empty", {30'd0, count}, 32'd0);

        // Flush with two words inside and an offered input.
        drive(1'b1, 16'h7777, 1'b0); tick();
        drive(1'b1, 16'h8888, 1'b0); tick();
        check_eq("fl_pre_count", {30'd0, count}, 32'd2);
        flush = 1'b1;
        drive(1'b1, 16'h9999, 1'b0);
        check_eq("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        check_eq("fl_count", {30'd0, count}, 32'd0);
        check_eq("fl_out_valid", {31'd0, out_valid}, 32'd0);

        // A push after flush takes DEPTH edges to emerge.
        drive(1'b1, 16'h5555, 1'b1); tick();
        drive(1'b0, 16'h0000, 1'b1); tick();
        check_eq("post_fl_early", {31'd0, out_valid}, 32'd0);
        tick();
        check_eq("post_fl_valid", {31'd0, out_valid}, 32'd1);
        check_eq("post_fl_q", {16'd0, q}, 32'h5555);
        check_eq("post_fl_count", {30'd0, count}, 32'd1);
        tick();
        check_eq("post_fl_empty", {31'd0, out_valid}, 32'd0);
        check_eq("post_fl_count0", {30'd0, count}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
